// File: rtl/spi_master_param_if.sv
// System-side request/response bundle of the parametrised SPI master.
// master: issuing logic; slave: the SPI engine.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic              start;
  logic [SEL_W-1:0]  slaveselect;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;

  modport master (
    output start, slaveselect, cpol, cpha, tx_data,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, slaveselect, cpol, cpha, tx_data,
    output rx_data, busy, done
  );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master, runtime CPOL/CPHA, one word per start.
// Define SPI_LSB_FIRST_EN for LSB-first bit order on mosi and miso.
module spi_master_param #(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = 2,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_master_param_if.slave     bus,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SLAVES-1:0] cs_n
);

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, HOLD, DONE
  } state_t;

  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int HALF_W = $clog2(2 * DATA_W);

  localparam logic [CNT_W-1:0] CMAX =
    CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SMAX =
    CNT_W'(CLK_DIV);
  localparam logic [HALF_W-1:0] HLAST =
    HALF_W'(2 * DATA_W - 1);
  localparam logic [SEL_W:0] NS_LIM =
    (SEL_W + 1)'(NUM_SLAVES);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   half;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic                pha;
  logic                sel_ok;
  logic                armed;
  logic                accept;
  logic                in_range;
  logic                lead;
  logic [NUM_SLAVES-1:0] cs_dec;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic head(
    input logic [DATA_W-1:0] d);
    return d[0];
  endfunction
  function automatic logic [DATA_W-1:0] adv(
    input logic [DATA_W-1:0] d);
    return d >> 1;
  endfunction
  function automatic logic [DATA_W-1:0] ins(
    input logic [DATA_W-1:0] d, input logic b);
    return {b, d[DATA_W-1:1]};
  endfunction
`else
  function automatic logic head(
    input logic [DATA_W-1:0] d);
    return d[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] adv(
    input logic [DATA_W-1:0] d);
    return d << 1;
  endfunction
  function automatic logic [DATA_W-1:0] ins(
    input logic [DATA_W-1:0] d, input logic b);
    return {d[DATA_W-2:0], b};
  endfunction
`endif

  assign accept   = (state == IDLE) && bus.start && armed;
  assign in_range = {1'b0, bus.slaveselect} < NS_LIM;
  // even half-periods end on the leading SCLK edge
  assign lead     = ~half[0];

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (bus.slaveselect == SEL_W'(i))
        cs_dec[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      half        <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      pha         <= 1'b0;
      sel_ok      <= 1'b0;
      armed       <= 1'b1;
      bus.rx_data <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= '1;
    end else begin
      bus.done <= 1'b0;
      if (!bus.start)
        armed <= 1'b1;
      else if (accept)
        armed <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          bus.busy <= 1'b1;
          sel_ok   <= in_range;
          pha      <= bus.cpha;
          half     <= '0;
          rx_sr    <= '0;
          if (in_range) begin
            state <= SETUP;
            cnt   <= '0;
            cs_n  <= cs_dec;
            sclk  <= bus.cpol;
            mosi  <= head(bus.tx_data);
            // cpha=1 re-drives the first bit on the leading edge
            tx_sr <= bus.cpha ? bus.tx_data
                              : adv(bus.tx_data);
          end else begin
            state <= HOLD;
            cnt   <= CMAX;
          end
        end
        SETUP: if (cnt == SMAX) begin
          state <= XFER;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        XFER: if (cnt == CMAX) begin
          cnt  <= '0;
          sclk <= ~sclk;
          half <= half + 1'b1;
          if (lead ^ pha) begin
            rx_sr <= ins(rx_sr, miso);
          end else begin
            mosi  <= head(tx_sr);
            tx_sr <= adv(tx_sr);
          end
          if (half == HLAST)
            state <= HOLD;
        end else begin
          cnt <= cnt + 1'b1;
        end
        HOLD: if (cnt == CMAX) begin
          state    <= DONE;
          cs_n     <= '1;
          mosi     <= 1'b0;
          bus.done <= 1'b1;
          if (sel_ok)
            bus.rx_data <= rx_sr;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param with a behavioural SPI slave.
`timescale 1ns/1ps
module tb_spi_master_param;

  localparam int DW = 8;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int CD = 4;
  localparam int LAT = (2 * DW + 2) * CD + 1;

  logic clk = 1'b0;
  logic reset;
  logic sclk, mosi;
  logic miso = 1'b0;
  logic [NS-1:0] cs_n;

  always #5 clk = ~clk;

  spi_master_param_if #(
    .DATA_W(DW), .SEL_W(SW)
  ) bus ();

  spi_master_param #(
    .DATA_W(DW), .NUM_SLAVES(NS),
    .SEL_W(SW), .CLK_DIV(CD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  // behavioural slave
  logic          s_pol = 1'b0;
  logic          s_pha = 1'b0;
  logic [DW-1:0] s_reply = '0;
  logic [DW-1:0] s_rx = '0;
  int            s_idx = 0;
  logic          cs_act = 1'b0;
  logic          s_lead;
  int            sclk_edges = 0;

  function automatic logic s_bit(input int i);
`ifdef SPI_LSB_FIRST_EN
    return s_reply[i];
`else
    return s_reply[DW-1-i];
`endif
  endfunction

  always @(cs_n) begin
    #1;
    if (~&cs_n && !cs_act) begin
      s_rx  = '0;
      s_idx = 0;
      if (!s_pha) begin
        miso  = s_bit(0);
        s_idx = 1;
      end
    end
    cs_act = ~&cs_n;
  end

  always @(sclk) begin
    sclk_edges++;
    if (cs_act) begin
      s_lead = (sclk != s_pol);
      if (s_lead ^ s_pha) begin
`ifdef SPI_LSB_FIRST_EN
        s_rx = {mosi, s_rx[DW-1:1]};
`else
        s_rx = {s_rx[DW-2:0], mosi};
`endif
      end else if (s_idx < DW) begin
        miso  = s_bit(s_idx);
        s_idx++;
      end
    end
  end

  // scoreboard
  typedef struct {
    logic [DW-1:0] rx;
    logic [DW-1:0] tx;
    logic          slv;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_done = 0;
  int   n_exp = 0;
  logic [DW-1:0] last_rx = '0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.done) begin
      n_done++;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("rx_data", 32'(bus.rx_data),
            32'(mon_e.rx));
        chk("latency", 32'(cyc - mon_e.acc),
            32'(mon_e.lat));
        chk("busy_at_done", 32'(bus.busy), 32'd1);
        if (mon_e.slv)
          chk("slave_rx", 32'(s_rx),
              32'(mon_e.tx));
      end
    end
  end

  function automatic logic first_of(
    input logic [DW-1:0] d);
`ifdef SPI_LSB_FIRST_EN
    return d[0];
`else
    return d[DW-1];
`endif
  endfunction

  task automatic push(input logic [DW-1:0] tx,
                      input logic [DW-1:0] reply,
                      input logic ok);
    exp_t e;
    e.rx  = ok ? reply : last_rx;
    e.tx  = tx;
    e.slv = ok;
    e.lat = ok ? LAT : 1;
    e.acc = cyc + 1;
    sb.push_back(e);
    n_exp++;
    if (ok)
      last_rx = reply;
  endtask

  task automatic xfer(input logic [SW-1:0] sel,
                      input logic pol,
                      input logic pha,
                      input logic [DW-1:0] tx,
                      input logic [DW-1:0] reply,
                      input logic [NS-1:0] exp_cs);
    logic ok;
    int   k;
    int   e0;
    logic got;
    ok = int'(sel) < NS;
    @(negedge clk);
    bus.slaveselect = sel;
    bus.cpol    = pol;
    bus.cpha    = pha;
    bus.tx_data = tx;
    s_pol   = pol;
    s_pha   = pha;
    s_reply = reply;
    bus.start = 1'b1;
    push(tx, reply, ok);
    e0  = sclk_edges;
    k   = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        chk("cs_n", 32'(cs_n), 32'(exp_cs));
        if (ok)
          chk("first_mosi", 32'(mosi),
              32'(first_of(tx)));
      end
      if (k == 3) begin
        bus.tx_data     = ~tx;
        bus.slaveselect = sel + 2'd1;
        bus.cpha        = ~pha;
      end
      if (bus.done)
        got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (!ok)
      chk("no_sclk", 32'(sclk_edges - e0), 32'd0);
    else
      chk("sclk_idle", 32'(sclk), 32'(pol));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #300us;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  int d0;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.slaveselect = '0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'h7);
    chk("rst_rx", 32'(bus.rx_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    xfer(2'd0, 1'b0, 1'b0, 8'hF0, 8'hA5, 3'b110);
    xfer(2'd2, 1'b1, 1'b1, 8'h55, 8'h3C, 3'b011);
    xfer(2'd3, 1'b1, 1'b0, 8'h77, 8'h12, 3'b111);

    // level start held: only one transfer
    @(negedge clk);
    bus.slaveselect = 2'd1;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.tx_data = 8'h9A;
    s_pol = 1'b0;
    s_pha = 1'b0;
    s_reply = 8'h66;
    d0 = n_done;
    bus.start = 1'b1;
    push(8'h9A, 8'h66, 1'b1);
    repeat (300) @(negedge clk);
    chk("hold_one_done", 32'(n_done - d0), 32'd1);
    bus.start = 1'b0;
    d0 = n_done;
    xfer(2'd1, 1'b0, 1'b0, 8'h3E, 8'hC1, 3'b101);
    chk("rearm_done", 32'(n_done - d0), 32'd1);

    // reset in the middle of a transfer
    @(negedge clk);
    bus.slaveselect = 2'd0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.tx_data = 8'hAA;
    s_reply = 8'h0F;
    bus.start = 1'b1;
    d0 = n_done;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_cs_n", 32'(cs_n), 32'h7);
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rx", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_rx = '0;
    repeat (100) @(negedge clk);
    chk("mid_rst_no_done", 32'(n_done - d0), 32'd0);

    xfer(2'd1, 1'b0, 1'b1, 8'h01, 8'h80, 3'b101);
    xfer(2'd0, 1'b1, 1'b0, 8'hC3, 8'h5A, 3'b110);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_total", 32'(n_done), 32'(n_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
